nonce_dispatcher: RTL

Scheduler for the bitcoin hash co-processor. It hands consecutive nonces (0 … NUM_NONCES-1) to NUM_CORES parallel SHA-256 double-hash cores and collects each core's final H0 word. It arbitrates the cores' results onto the single memory write port, writing H0 of nonce n to output_addr+n. It asserts done once every nonce's H0 has been written.

---
 rtl/bitcoin_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/nonce_dispatcher.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bitcoin_pkg.sv
// ---------------------------------------------------------------------------
// bitcoin_pkg
// Shared types and constants for the bitcoin hash co-processor blocks.
//   disp_state_t       : nonce dispatcher job state (IDLE / RUN / DONE)
//   nonce_cnt_w()      : width of a counter able to hold 0..num_nonces
//   DEFAULT_NUM_CORES  : default number of hash cores on the write port
//   DEFAULT_NUM_NONCES : default number of nonces per job
// ---------------------------------------------------------------------------
package bitcoin_pkg;

  localparam int DEFAULT_NUM_CORES  = 4;
  localparam int DEFAULT_NUM_NONCES = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } disp_state_t;

  // The counters must be able to hold NUM_NONCES itself (the terminal
  // value), not just the last nonce index.
  function automatic int nonce_cnt_w(input int num_nonces);
    return $clog2(num_nonces + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter. The request at or after the pointer (wrapping) wins.
// When advance is high and a grant was issued, the pointer moves to the
// index just past the winner.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   req        : N request lines
//   advance    : the current grant was consumed this cycle
//   grant      : one-hot grant (combinational from req and ptr)
//   ptr        : current highest-priority index
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] cand;
  logic [PW-1:0] grant_idx;
  logic          found;

  // Scan the requests starting at the pointer and take the first one seen.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      cand = PW'((int'(ptr) + off) % N);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  // Priority rotates to the slot after the last consumed grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// ---------------------------------------------------------------------------
// nonce_dispatcher
// Hands nonces 0..NUM_NONCES-1 to NUM_CORES hash cores, collects each
// core's final H0 word and writes H0 of nonce n to output_addr+n through a
// single memory write port. done rises once every nonce has been written.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start           : job request, honoured only in IDLE and DONE
//   output_addr     : base address of the result array, latched on start
//   done            : job complete, held until the next accepted start
//   core_ready      : per-core idle indication
//   core_start      : per-core one-cycle launch pulse
//   core_nonce      : per-core 32-bit nonce, held until that core finishes
//   core_done       : per-core one-cycle result-valid pulse
//   core_h0         : per-core 32-bit H0 result, valid with core_done
//   mem_we          : one-word write strobe
//   mem_addr        : write address
//   mem_write_data  : write data
// All outputs are registered.
// ---------------------------------------------------------------------------
module nonce_dispatcher
  import bitcoin_pkg::*;
#(
  parameter int NUM_CORES  = DEFAULT_NUM_CORES,
  parameter int NUM_NONCES = DEFAULT_NUM_NONCES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             output_addr,
  output logic                    done,
  input  logic [NUM_CORES-1:0]    core_ready,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES*32-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES*32-1:0] core_h0,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data
);

  localparam int CW = nonce_cnt_w(NUM_NONCES);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [CW-1:0] NONCE_END = CW'(NUM_NONCES);

  disp_state_t          state;
  logic [CW-1:0]        next_nonce;
  logic [CW-1:0]        written;
  logic [15:0]          addr_lat;
  logic [NUM_CORES-1:0] issued;
  logic [NUM_CORES-1:0] pending;
  logic [CW-1:0]        nonce_reg [NUM_CORES];
  logic [31:0]          res       [NUM_CORES];

  logic                 running;
  logic [NUM_CORES-1:0] free_cores;
  logic [NUM_CORES-1:0] disp_onehot;
  logic [NUM_CORES-1:0] arb_req;
  logic [NUM_CORES-1:0] grant;
  logic [NUM_CORES-1:0] collect;
  logic [NUM_CORES-1:0] issued_next;
  logic [NUM_CORES-1:0] pending_next;
  logic [CW-1:0]        grant_nonce;
  logic [31:0]          grant_res;
  logic [PW-1:0]        arb_ptr_unused;

  // A core holding an unwritten result is not free even if it reports
  // ready, so its nonce_reg and res stay valid until the write happens.
  // free & -free isolates the lowest-index free core.
  assign running     = (state == ST_RUN);
  assign free_cores  = core_ready & ~issued & ~pending;
  assign disp_onehot = (running && (next_nonce < NONCE_END))
                       ? (free_cores & (~free_cores + NUM_CORES'(1)))
                       : '0;
  assign arb_req     = running ? pending : '0;
  // A done pulse from a core we never launched is stale and dropped.
  assign collect     = running ? (core_done & issued) : '0;

  // The pointer is only observed for debug; the grant vector drives the port.
  rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (|grant),
    .grant   (grant),
    .ptr     (arb_ptr_unused)
  );

  // Next-state flag vectors and the one-hot mux of the granted core's
  // nonce and result onto the write port.
  always_comb begin
    issued_next  = (issued & ~collect) | disp_onehot;
    pending_next = (pending | collect) & ~grant;
    grant_nonce  = '0;
    grant_res    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        grant_nonce = grant_nonce | nonce_reg[i];
        grant_res   = grant_res | res[i];
      end
    end
  end

  // Job FSM with registered outputs. DONE is entered one cycle after the
  // final write so done never coincides with the last mem_we.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      next_nonce     <= '0;
      written        <= '0;
      addr_lat       <= '0;
      issued         <= '0;
      pending        <= '0;
      done           <= 1'b0;
      core_start     <= '0;
      core_nonce     <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        nonce_reg[i] <= '0;
        res[i]       <= '0;
      end
    end else begin
      core_start <= '0;
      mem_we     <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            addr_lat   <= output_addr;
            next_nonce <= '0;
            written    <= '0;
            issued     <= '0;
            pending    <= '0;
            done       <= 1'b0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          issued     <= issued_next;
          pending    <= pending_next;
          core_start <= disp_onehot;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (collect[i]) begin
              res[i] <= core_h0[i*32 +: 32];
            end
            if (disp_onehot[i]) begin
              nonce_reg[i]         <= next_nonce;
              core_nonce[i*32 +: 32] <= 32'(next_nonce);
            end
          end
          if (|disp_onehot) begin
            next_nonce <= next_nonce + CW'(1);
          end
          if (|grant) begin
            mem_we         <= 1'b1;
            mem_addr       <= addr_lat + 16'(grant_nonce);
            mem_write_data <= grant_res;
            written        <= written + CW'(1);
          end
          if (written == NONCE_END) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
